cm0_pc_trace_buf: RTL

Program-flow trace buffer for the Cortex-M0 integration level. Watches the core's program-counter visibility output and records every non-sequential PC (branch, exception entry/return, reset) with a cycle-delta timestamp into a parametrised circular buffer. Status inputs can freeze capture for post-mortem readout. Sits beside the processor integration wrapper on HCLK; software or a debug-side reader drains it through a valid/ready pop port.

---
 rtl/cm0_trace_pkg.sv | 35 +++
 rtl/cm0_trace_fifo.sv | 93 +++++++++
 rtl/cm0_pc_trace_buf.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cm0_trace_pkg.sv
// cm0_trace_pkg
// Shared definitions for the Cortex-M0 program-flow trace buffer:
// default field widths, the packed trace entry layout, the timestamp
// saturation value and a constant-foldable ceil(log2) helper.
package cm0_trace_pkg;

    localparam int unsigned PC_W_DEF    = 31;
    localparam int unsigned TS_W_DEF    = 16;
    localparam int unsigned ENTRY_W_DEF = PC_W_DEF + TS_W_DEF;

    // Delta counter stops here instead of wrapping, so a long stall
    // reads as "at least this many cycles" rather than a small bogus value.
    localparam logic [TS_W_DEF-1:0] TS_SAT_DEF = '1;

    // Entry layout: PC in the upper bits, cycle delta in the lower bits.
    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [TS_W_DEF-1:0] delta;
    } trace_entry_t;

    function automatic int unsigned f_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned f_entry_w(input int unsigned pc_w,
                                              input int unsigned ts_w);
        return pc_w + ts_w;
    endfunction

endpackage

// File: rtl/cm0_trace_fifo.sv
// cm0_trace_fifo
// Flop-array circular buffer holding trace entries.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (clears storage)
//   i_clear           flush pointers, count and overflow (storage kept)
//   i_push, i_data    write request and entry
//   i_ready           consumer takes the oldest entry when o_valid
//   o_valid, o_data   oldest entry, combinational from storage
//   o_count           occupancy, 0..DEPTH
//   o_overflow        sticky: an entry was dropped or overwritten
// WRAP=1 overwrites the oldest entry when full; WRAP=0 drops the new one.
module cm0_trace_fifo
    import cm0_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DW    = 47,
    parameter int unsigned WRAP  = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [DW-1:0]              o_data,
    output logic [f_clog2(DEPTH):0]    o_count,
    output logic                       o_overflow
);

    localparam int unsigned     ADDR_W   = f_clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam bit              WRAP_EN  = (WRAP != 0);

    logic [DW-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_full;
    logic w_pop;
    logic w_evict;
    logic w_write;

    assign w_full  = (r_count == FULL_CNT);
    // A pop on an empty buffer is ignored even if a push lands this cycle.
    assign w_pop   = (r_count != '0) & i_ready;
    // Push into a full buffer with no pop freeing a slot: something is lost.
    assign w_evict = i_push & w_full & ~w_pop;
    assign w_write = i_push & ~(w_evict & ~WRAP_EN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            // In wrap mode an eviction drags the read pointer along so the
            // buffer keeps the newest DEPTH entries.
            if (w_pop || (w_evict && WRAP_EN)) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_evict) begin
                r_overflow <= 1'b1;
            end
            if (w_write && !w_pop && !w_evict) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/cm0_pc_trace_buf.sv
// cm0_pc_trace_buf
// Program-flow trace buffer for the Cortex-M0 integration level. Records
// every non-sequential PC seen on vis_pc together with the number of cycles
// since the previous record.
// Ports:
//   HCLK, HRESET             clock, synchronous active-high reset
//   vis_pc                   core PC visibility (halfword address)
//   HALTED, LOCKUP           core status; rising edges can freeze capture
//   trace_en                 capture enable (level)
//   freeze_on_halt           HALTED rising edge also freezes capture
//   clear                    one-cycle flush of pointers, count and flags
//   out_valid/out_ready      pop handshake for the oldest entry
//   out_pc, out_delta        oldest entry fields
//   count                    occupancy
//   overflow, frozen         sticky status flags
module cm0_pc_trace_buf
    import cm0_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PC_W  = 31,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned WRAP  = 1
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [PC_W-1:0]          vis_pc,
    input  logic                     HALTED,
    input  logic                     LOCKUP,
    input  logic                     trace_en,
    input  logic                     freeze_on_halt,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [TS_W-1:0]          out_delta,
    output logic [f_clog2(DEPTH):0]  count,
    output logic                     overflow,
    output logic                     frozen
);

    localparam int unsigned     ENTRY_W = f_entry_w(PC_W, TS_W);
    localparam logic [TS_W-1:0] TS_MAX  = '1;

    logic [PC_W-1:0] r_prev_pc;
    logic            r_prev_vld;
    logic [TS_W-1:0] r_delta;
    logic            r_lockup_d;
    logic            r_halted_d;
    logic            r_frozen;

    logic [PC_W-1:0]    w_step;
    logic               w_disc;
    logic               w_push;
    logic               w_freeze_evt;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_out_entry;

    // Stall, 16-bit and 32-bit steps are sequential; the modular difference
    // handles PC wrap at the top of the address space.
    assign w_step       = vis_pc - r_prev_pc;
    assign w_disc       = (w_step > PC_W'(2));
    assign w_push       = trace_en & ~r_frozen & (~r_prev_vld | w_disc);
    assign w_freeze_evt = (LOCKUP & ~r_lockup_d)
                        | (freeze_on_halt & HALTED & ~r_halted_d);
    assign w_entry      = {vis_pc, r_delta};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_prev_pc  <= '0;
            r_prev_vld <= 1'b0;
            r_delta    <= '0;
            r_lockup_d <= 1'b0;
            r_halted_d <= 1'b0;
            r_frozen   <= 1'b0;
        end else begin
            r_lockup_d <= LOCKUP;
            r_halted_d <= HALTED;
            if (clear) begin
                r_prev_vld <= 1'b0;
                r_delta    <= '0;
                r_frozen   <= 1'b0;
            end else begin
                r_prev_vld <= trace_en;
                if (trace_en) begin
                    r_prev_pc <= vis_pc;
                end
                // Reload to 1: the cycle after a push is one cycle after it.
                if (w_push) begin
                    r_delta <= TS_W'(1);
                end else if (r_delta != TS_MAX) begin
                    r_delta <= r_delta + 1'b1;
                end
                if (w_freeze_evt) begin
                    r_frozen <= 1'b1;
                end
            end
        end
    end

    cm0_trace_fifo #(
        .DEPTH (DEPTH),
        .DW    (ENTRY_W),
        .WRAP  (WRAP)
    ) u_fifo (
        .i_clk      (HCLK),
        .i_rst      (HRESET),
        .i_clear    (clear),
        .i_push     (w_push),
        .i_data     (w_entry),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_data     (w_out_entry),
        .o_count    (count),
        .o_overflow (overflow)
    );

    assign out_pc    = w_out_entry[ENTRY_W-1:TS_W];
    assign out_delta = w_out_entry[TS_W-1:0];
    assign frozen    = r_frozen;

endmodule
